// File: rtl/link_pkg.sv
// Shared definitions for the buffered four-phase link slave.
// Holds the FSM state type and the default parameter values.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        HOLD_ACK = 2'd2,
        WAIT_REQ = 2'd3
    } link_state_t;

    localparam int LINK_DATA_W_DEF   = 8;
    localparam int LINK_DEPTH_DEF    = 4;
    localparam int LINK_ACK_HOLD_DEF = 2;

endpackage

// File: rtl/link_sync_fifo.sv
// Single-clock FIFO with a registered head word.
// The head register is loaded from the array (registered read) or bypassed
// from the write port when the incoming word becomes the new head.
module link_sync_fifo import link_pkg::*; #(
    parameter int DATA_W = LINK_DATA_W_DEF,
    parameter int DEPTH  = LINK_DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] head_reg;
    logic              push_eff;
    logic              pop_eff;
    logic              head_bypass;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop on an empty FIFO is ignored; a push on a full one only if it pops too
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    assign rd_ptr_next = pop_eff ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    // The written word is the head after this edge when nothing older remains
    assign head_bypass = push_eff && (empty || ((count_reg == CNT_W'(1)) && pop_eff));

    // Storage array: no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered head word, valid whenever the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg <= '0;
        end else if (head_bypass) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    assign head_data = head_reg;
    assign level     = count_reg;

endmodule

// File: rtl/link_slave_fifo.sv
// Four-phase link slave feeding a FIFO with a valid/ready output side.
// While the FIFO is full the slave holds off ack rather than dropping words.
// Optional even-parity checking on the link is enabled by LINK_PARITY_EN.
module link_slave_fifo import link_pkg::*; #(
    parameter int DATA_W   = LINK_DATA_W_DEF,
    parameter int DEPTH    = LINK_DEPTH_DEF,
    parameter int ACK_HOLD = LINK_ACK_HOLD_DEF,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    output logic              ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  level,
`ifdef LINK_PARITY_EN
    input  logic              par,
    output logic              err,
`endif
    output logic              stall
);

    localparam int HOLD_W = $clog2(ACK_HOLD + 1);

    link_state_t       state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              ack_reg;
    logic              stall_reg;
    logic              word_ok;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef LINK_PARITY_EN
    logic err_reg;
    assign word_ok = ~(^{data, par});
`else
    assign word_ok = 1'b1;
`endif

    // The word on the link is captured while leaving LATCH
    assign fifo_push = (state_reg == LATCH) && word_ok;

    link_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (data),
        .pop       (out_ready),
        .head_data (out_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshake FSM with ack hold counter; full is only looked at in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ack_reg      <= 1'b0;
            hold_cnt_reg <= '0;
            stall_reg    <= 1'b0;
        end else begin
            stall_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ack_reg   <= 1'b0;
                    stall_reg <= req && fifo_full;
                    if (req && !fifo_full) begin
                        state_reg <= LATCH;
                    end
                end
                LATCH: begin
                    ack_reg      <= 1'b1;
                    hold_cnt_reg <= '0;
                    state_reg    <= HOLD_ACK;
                end
                HOLD_ACK: begin
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    if (hold_cnt_reg == HOLD_W'(ACK_HOLD - 1)) begin
                        ack_reg   <= 1'b0;
                        state_reg <= WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    ack_reg <= 1'b0;
                    if (!req) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ack_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef LINK_PARITY_EN
    // Sticky parity error: set by a bad word in LATCH, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if ((state_reg == LATCH) && !word_ok) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`endif

    assign ack       = ack_reg;
    assign stall     = stall_reg;
    assign out_valid = !fifo_empty;

endmodule
